// File: rtl/ramsdp_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ramsdp_port_arbiter.
// The master side drives requests and ram_q; the slave side is the arbiter.
interface ramsdp_port_arbiter_if #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RD     = 4
);
    logic [NUM_RD-1:0]            rd_req;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_gnt;
    logic [NUM_RD-1:0]            rd_valid;
    logic [BUS_WIDTH-1:0]         rd_data;
    logic [1:0]                   wr_req;
    logic [2*ADDR_WIDTH-1:0]      wr_addr;
    logic [2*BUS_WIDTH-1:0]       wr_data;
    logic [1:0]                   wr_gnt;
    logic [ADDR_WIDTH-1:0]        ram_rdaddress;
    logic [BUS_WIDTH-1:0]         ram_q;
    logic                         ram_wren;
    logic [ADDR_WIDTH-1:0]        ram_wraddress;
    logic [BUS_WIDTH-1:0]         ram_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_q,
        input  rd_gnt, rd_valid, rd_data, wr_gnt,
        input  ram_rdaddress, ram_wren, ram_wraddress, ram_data
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_q,
        output rd_gnt, rd_valid, rd_data, wr_gnt,
        output ram_rdaddress, ram_wren, ram_wraddress, ram_data
    );
endinterface

// File: rtl/ramsdp_port_arbiter.sv
// Round-robin read / fixed-priority write arbiter in front of one RAMSDP.
// Read grants travel down a tag pipeline matching the RAM read latency.
module ramsdp_port_arbiter #(
    parameter int BUS_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_RD       = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ramsdp_port_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_RD);

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW:0]       scan;
    logic              gnt_any;
    logic [NUM_RD-1:0] gnt_vec;
    logic [NUM_RD-1:0] tag_pipe [READ_LATENCY];
    logic [1:0]        wgnt;

    // Search starts at rr_ptr and wraps; first asserted request wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        scan    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan >= (PW+1)'(NUM_RD)) begin
                scan = scan - (PW+1)'(NUM_RD);
            end
            if (!gnt_any && bus.rd_req[scan[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PW-1:0];
            end
        end
        if (!reset_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        bus.ram_rdaddress = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (gnt_vec[i]) begin
                bus.ram_rdaddress = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            if (gnt_idx == PW'(NUM_RD-1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

    // Clearing on reset drops every in-flight read tag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= gnt_vec;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign bus.rd_gnt   = gnt_vec;
    assign bus.rd_valid = reset_n ? tag_pipe[READ_LATENCY-1] : '0;
    assign bus.rd_data  = bus.ram_q;

    // Writer 0 always wins; writer 0 also steers the mux when idle.
    always_comb begin
        wgnt = '0;
        if (reset_n) begin
            wgnt[0] = bus.wr_req[0];
            wgnt[1] = bus.wr_req[1] & ~bus.wr_req[0];
        end
    end

    always_comb begin
        bus.wr_gnt   = wgnt;
        bus.ram_wren = |wgnt;
        if (wgnt[1]) begin
            bus.ram_wraddress = bus.wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
            bus.ram_data      = bus.wr_data[BUS_WIDTH +: BUS_WIDTH];
        end else begin
            bus.ram_wraddress = bus.wr_addr[0 +: ADDR_WIDTH];
            bus.ram_data      = bus.wr_data[0 +: BUS_WIDTH];
        end
    end
endmodule
